// File: rtl/fastica_pkg.sv
// Shared types and constants for the FastICA unmixing pipeline.
// Element format is signed fixed point, W bits with FRAC fractional bits.
// Matrices are 4x4, flattened row-major with idx(r,c) selecting the element slot.
package fastica_pkg;

  localparam int W    = 26;
  localparam int FRAC = 13;
  localparam int N    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Flat element slot of matrix element (r,c)
  function automatic int idx(input int r, input int c);
    return N * r + c;
  endfunction

endpackage

// File: rtl/conv_row_max.sv
// Combinational maximum of one 4-element matrix row.
// Latency: zero cycles, pure combinational.
// Backpressure: none; the parent selects which row is presented.
module conv_row_max
  import fastica_pkg::*;
(
  input  logic [N*W-1:0] elems_i,
  output logic [W-1:0]   max_o
);

  logic [W-1:0] elem;

  // Negative entries are corrupt magnitudes; clamp them to the largest positive
  // value so they can only ever push the result away from convergence.
  always_comb begin
    max_o = '0;
    elem  = '0;
    for (int c = 0; c < N; c++) begin
      elem = elems_i[c*W +: W];
      if (elem[W-1]) begin
        elem = {1'b0, {(W-1){1'b1}}};
      end
      if (elem > max_o) begin
        max_o = elem;
      end
    end
  end

endmodule

// File: rtl/conv_check.sv
// Convergence checker: max |error| of a 4x4 matrix vs TOL, iteration count, decision.
// Latency: accept at edge T, out_valid high after edge T+6 (4 scan + decide + output register).
// Backpressure: in_ready only in IDLE; decision held in HOLD until out_ready.
module conv_check
  import fastica_pkg::*;
#(
  parameter int TOL      = 8,
  parameter int MAX_ITER = 64,
  parameter int CNT_W    = 7
) (
  input  logic               clk_conv,
  input  logic               rstn_conv,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*N*W-1:0]   err_flat,
  input  logic [N*N*W-1:0]   w_flat,
  input  logic               iter_clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               converged,
  output logic               timeout,
  output logic [CNT_W-1:0]   iter_cnt,
  output logic [W-1:0]       max_err,
  output logic [N*N*W-1:0]   w_out_flat
);

  localparam logic signed [W-1:0] TOL_S = W'(TOL);
  localparam logic [CNT_W-1:0]    MAX_C = CNT_W'(MAX_ITER);

  state_e             state_q, state_d;
  logic [1:0]         row_q;
  logic [N*N*W-1:0]   err_q;
  logic [N*N*W-1:0]   w_q;
  logic [W-1:0]       acc_q;
  logic [W-1:0]       max_q;
  logic               out_valid_q;
  logic               conv_q;
  logic               tmo_q;
  logic [CNT_W-1:0]   iter_q, iter_d;

  logic [N*W-1:0]     row_dat;
  logic [W-1:0]       row_max;
  logic [W-1:0]       acc_next;
  logic [CNT_W-1:0]   iter_inc;
  logic               conv_d;
  logic               tmo_d;

  // Present the row addressed by the row counter to the max unit
  always_comb begin
    row_dat = err_q[idx(int'(row_q), 0)*W +: N*W];
  end

  conv_row_max u_row_max (
    .elems_i (row_dat),
    .max_o   (row_max)
  );

  // Running maximum and the decision terms derived from it
  always_comb begin
    acc_next = (row_max > acc_q) ? row_max : acc_q;
    iter_inc = (iter_q >= MAX_C) ? MAX_C : iter_q + CNT_W'(1);
    conv_d   = $signed(acc_q) < TOL_S;
    tmo_d    = !conv_d && (iter_d >= MAX_C);
  end

  // Iteration count: a clear coinciding with DECIDE still counts this iteration
  always_comb begin
    iter_d = iter_q;
    if (state_q == DECIDE) begin
      iter_d = iter_clear ? CNT_W'(1) : iter_inc;
    end else if (iter_clear) begin
      iter_d = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk_conv) begin
    if (!rstn_conv) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)                 state_d = SCAN;
      SCAN:    if (row_q == 2'd3)            state_d = DECIDE;
      DECIDE:                                state_d = HOLD;
      HOLD:    if (out_valid_q && out_ready) state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == IDLE);
  end

  // Capture, row scan, decision and output registers
  always_ff @(posedge clk_conv) begin
    if (!rstn_conv) begin
      row_q       <= '0;
      err_q       <= '0;
      w_q         <= '0;
      acc_q       <= '0;
      max_q       <= '0;
      out_valid_q <= 1'b0;
      conv_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            err_q <= err_flat;
            w_q   <= w_flat;
            acc_q <= '0;
            row_q <= '0;
          end
        end
        SCAN: begin
          acc_q <= acc_next;
          row_q <= row_q + 2'd1;
        end
        DECIDE: begin
          max_q  <= acc_q;
          conv_q <= conv_d;
          tmo_q  <= tmo_d;
        end
        HOLD: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Iteration counter register
  always_ff @(posedge clk_conv) begin
    if (!rstn_conv) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign converged  = conv_q;
  assign timeout    = tmo_q;
  assign iter_cnt   = iter_q;
  assign max_err    = max_q;
  assign w_out_flat = w_q;

endmodule

// File: tb/tb_conv_check.sv
// Bench for conv_check: reset, vector table, randomized runs against a reference model,
// timeout saturation, HOLD stall, iter_clear in DECIDE and reset during scan.
module tb_conv_check;

  localparam int W    = 26;
  localparam int MW   = 16 * W;
  localparam int TOLV = 8;
  localparam int MAXI = 64;
  localparam int CLMP = 33554431;

  logic          clk_conv = 1'b0;
  logic          rstn_conv;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] err_flat;
  logic [MW-1:0] w_flat;
  logic          iter_clear;
  logic          out_valid;
  logic          out_ready;
  logic          converged;
  logic          timeout;
  logic [6:0]    iter_cnt;
  logic [W-1:0]  max_err;
  logic [MW-1:0] w_out_flat;

  int errs   = 0;
  int checks = 0;
  int miter  = 0;

  always #5 clk_conv = ~clk_conv;

  conv_check dut (
    .clk_conv   (clk_conv),
    .rstn_conv  (rstn_conv),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .err_flat   (err_flat),
    .w_flat     (w_flat),
    .iter_clear (iter_clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .converged  (converged),
    .timeout    (timeout),
    .iter_cnt   (iter_cnt),
    .max_err    (max_err),
    .w_out_flat (w_out_flat)
  );

  typedef struct {
    int fill;
    int r;
    int c;
    int val;
    int exp_max;
    bit exp_conv;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk(input int fill, input int r, input int c, input int val);
    logic [MW-1:0] m;
    for (int i = 0; i < 16; i++) m[i*W +: W] = W'(fill);
    m[(4*r+c)*W +: W] = W'(val);
    return m;
  endfunction

  function automatic logic [MW-1:0] rnd_mat();
    logic [MW-1:0] m;
    for (int i = 0; i < 16; i++) m[i*W +: W] = W'($urandom);
    return m;
  endfunction

  // Reference: largest magnitude with any negative entry counted as the clamp value
  function automatic int ref_max(input logic [MW-1:0] m);
    int best = 0;
    int v;
    for (int i = 0; i < 16; i++) begin
      v = int'($signed(m[i*W +: W]));
      if (v < 0) v = CLMP;
      if (v > best) best = v;
    end
    return best;
  endfunction

  function automatic int model_step(input int it);
    return (it >= MAXI) ? MAXI : it + 1;
  endfunction

  // Offer a matrix, then wait for the decision; lat counts edges after acceptance.
  // iter_clear is pulsed at lat == clr_j (-1 for none).
  task automatic send(input logic [MW-1:0] e, input logic [MW-1:0] w, input int clr_j,
                      output int lat);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk_conv);
      n++;
    end
    in_valid = 1'b1;
    err_flat = e;
    w_flat   = w;
    @(negedge clk_conv);
    in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      iter_clear = (lat == clr_j);
      if (out_valid) break;
      @(negedge clk_conv);
      lat++;
    end
    iter_clear = 1'b0;
    if (lat >= 20) chk("decision_wait", lat, 6);
  endtask

  // Let the held decision be consumed (out_ready is high) and return to IDLE
  task automatic drain();
    @(negedge clk_conv);
  endtask

  // Send one matrix, compare against the model, drain
  task automatic run_model(input string nm, input logic [MW-1:0] e);
    int lat;
    int em;
    bit ec;
    logic [MW-1:0] w;
    w  = rnd_mat();
    send(e, w, -1, lat);
    em    = ref_max(e);
    ec    = (em < TOLV);
    miter = model_step(miter);
    chk({nm, "_max"}, max_err, em);
    chk({nm, "_conv"}, converged, ec);
    chk({nm, "_iter"}, iter_cnt, miter);
    chk({nm, "_tmo"}, timeout, (!ec && miter >= MAXI));
    drain();
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int seen;
    logic [MW-1:0] m;
    logic [MW-1:0] w;
    logic [W-1:0]  hold_max;

    vecs[0] = '{3, 0, 0, 3, 3, 1'b1};
    vecs[1] = '{0, 2, 1, 8, 8, 1'b0};
    vecs[2] = '{0, 3, 3, -5, CLMP, 1'b0};
    vecs[3] = '{0, 0, 0, 0, 0, 1'b1};
    vecs[4] = '{0, 1, 2, 7, 7, 1'b1};
    vecs[5] = '{5, 0, 3, -33554432, CLMP, 1'b0};
    vecs[6] = '{100, 3, 0, CLMP, CLMP, 1'b0};
    vecs[7] = '{2, 2, 2, 9, 9, 1'b0};

    rstn_conv  = 1'b0;
    in_valid   = 1'b0;
    err_flat   = '0;
    w_flat     = '0;
    iter_clear = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk_conv);
    @(negedge clk_conv);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_conv", converged, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_max", max_err, 0);
    chk_w("rst_wout", w_out_flat, '0);
    rstn_conv = 1'b1;
    @(negedge clk_conv);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      m = mk(vecs[i].fill, vecs[i].r, vecs[i].c, vecs[i].val);
      w = rnd_mat();
      send(m, w, -1, lat);
      miter = model_step(miter);
      chk("vec_latency", lat, 6);
      chk("vec_max", max_err, vecs[i].exp_max);
      chk("vec_conv", converged, vecs[i].exp_conv);
      chk("vec_tmo", timeout, 0);
      chk("vec_iter", iter_cnt, miter);
      chk_w("vec_wout", w_out_flat, w);
      drain();
      chk("vec_back_idle", in_ready, 1);
      chk("vec_ov_low", out_valid, 0);
    end

    // Timeout ramp: 65 non-converging matrices with max 100 after a clear
    iter_clear = 1'b1;
    @(negedge clk_conv);
    iter_clear = 1'b0;
    miter = 0;
    chk("clear_idle", iter_cnt, 0);
    for (int k = 0; k < 65; k++) begin
      m = '0;
      for (int i = 0; i < 16; i++) m[i*W +: W] = W'($urandom_range(0, 100));
      m[$urandom_range(0, 15)*W +: W] = W'(100);
      run_model("ramp", m);
    end
    chk("ramp_final_iter", iter_cnt, 64);
    chk("ramp_final_tmo", timeout, 1);

    // Random matrices while saturated: small values, some negatives
    for (int k = 0; k < 30; k++) begin
      m = '0;
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 40) == 0) m[i*W +: W] = W'(-$urandom_range(1, 1000));
        else m[i*W +: W] = W'($urandom_range(0, (k % 2 == 0) ? 7 : 12));
      end
      run_model("rnd", m);
    end

    // HOLD stall: out_ready low for 10 cycles while offering new data
    iter_clear = 1'b1;
    @(negedge clk_conv);
    iter_clear = 1'b0;
    miter = 0;
    out_ready = 1'b0;
    w = rnd_mat();
    send(mk(1, 1, 1, 50), w, -1, lat);
    miter = model_step(miter);
    chk("hold_latency", lat, 6);
    hold_max = max_err;
    chk("hold_max0", hold_max, 50);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      err_flat = mk(0, 0, 0, 3);
      w_flat   = rnd_mat();
      @(negedge clk_conv);
      chk("hold_ov", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_max", max_err, hold_max);
      chk_w("hold_wout", w_out_flat, w);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk_conv);
    chk("hold_release_ov", out_valid, 0);
    chk("hold_release_idle", in_ready, 1);
    @(negedge clk_conv);
    chk_w("hold_no_capture", w_out_flat, w);
    chk("hold_iter", iter_cnt, 1);

    // iter_clear during DECIDE of iteration 5
    iter_clear = 1'b1;
    @(negedge clk_conv);
    iter_clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(mk(0, 0, 0, 20), rnd_mat(), -1, lat);
      drain();
    end
    chk("pre_clear_iter", iter_cnt, 4);
    send(mk(0, 0, 0, 20), rnd_mat(), 4, lat);
    chk("decide_clear_iter", iter_cnt, 1);
    chk("decide_clear_latency", lat, 6);
    chk("decide_clear_max", max_err, 20);
    drain();
    send(mk(0, 0, 0, 2), rnd_mat(), 1, lat);
    chk("scan_clear_iter", iter_cnt, 1);
    chk("scan_clear_conv", converged, 1);
    drain();

    // Reset asserted mid-scan discards the partial result
    in_valid = 1'b1;
    err_flat = mk(0, 2, 2, 40);
    w_flat   = rnd_mat();
    @(negedge clk_conv);
    in_valid = 1'b0;
    @(negedge clk_conv);
    @(negedge clk_conv);
    rstn_conv = 1'b0;
    @(negedge clk_conv);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_iter", iter_cnt, 0);
    chk("mid_rst_max", max_err, 0);
    chk("mid_rst_conv", converged, 0);
    chk_w("mid_rst_wout", w_out_flat, '0);
    rstn_conv = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_conv);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_ov", seen, 0);
    miter = 0;
    run_model("post_rst", mk(0, 3, 1, 6));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
